// File: rtl/dmem_pkg.sv
// ---------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the data-memory port arbiter:
//   req_id_e   - requester identifier (REQ_R0 = 0, REQ_R1 = 1)
//   RD_LATENCY - cycles from a granted read to its rvalid pulse
//   rd_tag_t   - in-flight read owner tag (valid bit + requester id)
// ---------------------------------------------------------------------------
package dmem_pkg;

  typedef enum logic {
    REQ_R0 = 1'b0,
    REQ_R1 = 1'b1
  } req_id_e;

  // The memory wrapper returns read data one cycle after the access, so a
  // single tag register is enough to route it back to its owner.
  localparam int RD_LATENCY = 1;

  typedef struct packed {
    logic    valid;
    req_id_e id;
  } rd_tag_t;

endpackage : dmem_pkg

// File: rtl/dmem_port_arbiter_rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin arbiter with its priority register.
// Ports:
//   i_clk     - clock
//   i_rstn    - asynchronous active-low reset (priority returns to r0)
//   i_req     - request vector, bit 0 = r0, bit 1 = r1
//   o_gnt     - one-hot (or zero) grant, combinational on i_req
//   o_gnt_id  - id of the granted requester (meaningful when |o_gnt)
// ---------------------------------------------------------------------------
module rr_arb2
  import dmem_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt,
  output req_id_e    o_gnt_id
);

  req_id_e prio_reg;
  req_id_e prio_next;
  logic [1:0] gnt;

  // A lone requester always wins; prio only breaks ties.
  always_comb begin
    gnt = i_req;
    if (i_req == 2'b11) begin
      gnt = (prio_reg == REQ_R0) ? 2'b01 : 2'b10;
    end
  end

  // After any grant the other port gets priority; idle cycles hold it.
  always_comb begin
    prio_next = prio_reg;
    if (gnt[0]) begin
      prio_next = REQ_R1;
    end else if (gnt[1]) begin
      prio_next = REQ_R0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      prio_reg <= REQ_R0;
    end else begin
      prio_reg <= prio_next;
    end
  end

  assign o_gnt    = gnt;
  assign o_gnt_id = gnt[1] ? REQ_R1 : REQ_R0;

endmodule : rr_arb2

// File: rtl/dmem_port_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_port_arbiter
// Shares one data-memory port between two requesters (r0, r1) with
// round-robin arbitration and routes read data back to the issuing port.
// Ports:
//   i_clk, i_rstn                      - clock, async active-low reset
//   i_rN_req/_we/_addr/_wdata          - requester N access (we == 0: read)
//   o_rN_gnt                           - access accepted this cycle
//   o_rN_rvalid/_rdata                 - read return, one cycle after grant
//   o_m_ce/_we/_addr/_data_in          - memory-side command (granted port)
//   i_m_data_out                       - memory read data (registered)
// ---------------------------------------------------------------------------
module dmem_port_arbiter
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int BYTE_WIDTH = 8,
  localparam int NB        = DATA_WIDTH / BYTE_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_r0_req,
  input  logic [NB-1:0]         i_r0_we,
  input  logic [ADDR_WIDTH-1:0] i_r0_addr,
  input  logic [DATA_WIDTH-1:0] i_r0_wdata,
  input  logic                  i_r1_req,
  input  logic [NB-1:0]         i_r1_we,
  input  logic [ADDR_WIDTH-1:0] i_r1_addr,
  input  logic [DATA_WIDTH-1:0] i_r1_wdata,
  output logic                  o_r0_gnt,
  output logic                  o_r1_gnt,
  output logic                  o_r0_rvalid,
  output logic                  o_r1_rvalid,
  output logic [DATA_WIDTH-1:0] o_r0_rdata,
  output logic [DATA_WIDTH-1:0] o_r1_rdata,
  output logic                  o_m_ce,
  output logic [NB-1:0]         o_m_we,
  output logic [ADDR_WIDTH-1:0] o_m_addr,
  output logic [DATA_WIDTH-1:0] o_m_data_in,
  input  logic [DATA_WIDTH-1:0] i_m_data_out
);

  logic [1:0] req_vec;
  logic [1:0] gnt_vec;
  req_id_e    gnt_id;
  rd_tag_t    rd_tag_reg;
  rd_tag_t    rd_tag_next;
  logic [1:0] rvalid_vec;

  // Requests are masked while reset is held so no grant or memory command
  // can leak out combinationally during reset.
  assign req_vec = {i_r1_req, i_r0_req} & {2{i_rstn}};

  rr_arb2 u_rr_arb2 (
    .i_clk    (i_clk),
    .i_rstn   (i_rstn),
    .i_req    (req_vec),
    .o_gnt    (gnt_vec),
    .o_gnt_id (gnt_id)
  );

  assign o_r0_gnt = gnt_vec[0];
  assign o_r1_gnt = gnt_vec[1];

  // Memory command mux; everything is zero when nobody is granted.
  always_comb begin
    o_m_ce      = 1'b0;
    o_m_we      = '0;
    o_m_addr    = '0;
    o_m_data_in = '0;
    if (gnt_vec[0]) begin
      o_m_ce      = 1'b1;
      o_m_we      = i_r0_we;
      o_m_addr    = i_r0_addr;
      o_m_data_in = i_r0_wdata;
    end else if (gnt_vec[1]) begin
      o_m_ce      = 1'b1;
      o_m_we      = i_r1_we;
      o_m_addr    = i_r1_addr;
      o_m_data_in = i_r1_wdata;
    end
  end

  // Owner tag is captured at grant time, so the returning word is steered
  // by who issued it rather than by who holds the grant now; this lets
  // alternating back-to-back reads return without bubbles.
  always_comb begin
    rd_tag_next.valid = o_m_ce && (o_m_we == '0);
    rd_tag_next.id    = gnt_id;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      rd_tag_reg <= '{valid: 1'b0, id: REQ_R0};
    end else begin
      rd_tag_reg <= rd_tag_next;
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_rvalid
      assign rvalid_vec[gi] = rd_tag_reg.valid && (int'(rd_tag_reg.id) == gi);
    end
  endgenerate

  assign o_r0_rvalid = rvalid_vec[0];
  assign o_r1_rvalid = rvalid_vec[1];
  assign o_r0_rdata  = rvalid_vec[0] ? i_m_data_out : '0;
  assign o_r1_rdata  = rvalid_vec[1] ? i_m_data_out : '0;

endmodule : dmem_port_arbiter

// File: tb/tb_dmem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_port_arbiter
// Directed stimulus with a scoreboard: each expected read return is queued
// when the read is issued and a negedge monitor pops and compares it when
// the DUT presents rvalid. A small byte-enabled memory with a registered
// read port stands in for the data memory wrapper.
// ---------------------------------------------------------------------------
module tb_dmem_port_arbiter;

  logic        clk;
  logic        rstn;
  logic        r0_req, r1_req;
  logic [3:0]  r0_we, r1_we;
  logic [9:0]  r0_addr, r1_addr;
  logic [31:0] r0_wdata, r1_wdata;
  logic        r0_gnt, r1_gnt;
  logic        r0_rvalid, r1_rvalid;
  logic [31:0] r0_rdata, r1_rdata;
  logic        m_ce;
  logic [3:0]  m_we;
  logic [9:0]  m_addr;
  logic [31:0] m_data_in;
  logic [31:0] m_data_out;

  // memory preload path, used only while the DUT is held in reset
  logic        pl_en;
  logic [9:0]  pl_addr;
  logic [31:0] pl_data;
  logic [31:0] mem [0:1023];

  typedef struct {
    bit          port;
    logic [31:0] data;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  dmem_port_arbiter #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (10),
    .BYTE_WIDTH (8)
  ) dut (
    .i_clk        (clk),
    .i_rstn       (rstn),
    .i_r0_req     (r0_req),
    .i_r0_we      (r0_we),
    .i_r0_addr    (r0_addr),
    .i_r0_wdata   (r0_wdata),
    .i_r1_req     (r1_req),
    .i_r1_we      (r1_we),
    .i_r1_addr    (r1_addr),
    .i_r1_wdata   (r1_wdata),
    .o_r0_gnt     (r0_gnt),
    .o_r1_gnt     (r1_gnt),
    .o_r0_rvalid  (r0_rvalid),
    .o_r1_rvalid  (r1_rvalid),
    .o_r0_rdata   (r0_rdata),
    .o_r1_rdata   (r1_rdata),
    .o_m_ce       (m_ce),
    .o_m_we       (m_we),
    .o_m_addr     (m_addr),
    .o_m_data_in  (m_data_in),
    .i_m_data_out (m_data_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // memory model: byte-enabled write, registered read
  always @(posedge clk) begin
    if (pl_en) begin
      mem[pl_addr] <= pl_data;
    end else if (m_ce) begin
      if (m_we == 4'h0) begin
        m_data_out <= mem[m_addr];
      end else begin
        for (int b = 0; b < 4; b++) begin
          if (m_we[b]) mem[m_addr][8*b +: 8] <= m_data_in[8*b +: 8];
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // monitor: every negedge, any queued read must be answered now
  always @(negedge clk) begin
    exp_t e;
    if (r0_rvalid && r1_rvalid) begin
      n_cmp++; n_err++;
      $display("FAIL rvalid_both: got r0=1 r1=1 expected at most one");
    end else if (r0_rvalid || r1_rvalid) begin
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_err++;
        $display("FAIL rvalid_unexpected: got r0=%0b r1=%0b expected none", r0_rvalid, r1_rvalid);
      end else begin
        e = sb_q.pop_front();
        check("rvalid_port", {31'd0, r1_rvalid}, {31'd0, e.port});
        check("rdata", r1_rvalid ? r1_rdata : r0_rdata, e.data);
      end
    end else if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      n_cmp++; n_err++;
      $display("FAIL rvalid_missing: got none expected port %0d data 0x%08h", e.port, e.data);
    end
    if (!r0_rvalid) check("r0_rdata_idle_zero", r0_rdata, 32'h0);
    if (!r1_rvalid) check("r1_rdata_idle_zero", r1_rdata, 32'h0);
  end

  // Drives one cycle's requests, checks grants #1 later and queues the
  // expected read return. The caller advances to the next negedge.
  task automatic drive(input string name,
                       input bit q0, input logic [3:0] w0, input logic [9:0] a0, input logic [31:0] d0,
                       input bit q1, input logic [3:0] w1, input logic [9:0] a1, input logic [31:0] d1,
                       input bit eg0, input bit eg1, input bit push, input logic [31:0] erd);
    exp_t e;
    r0_req = q0; r0_we = w0; r0_addr = a0; r0_wdata = d0;
    r1_req = q1; r1_we = w1; r1_addr = a1; r1_wdata = d1;
    #1;
    check({name, "_gnt0"}, {31'd0, r0_gnt}, {31'd0, eg0});
    check({name, "_gnt1"}, {31'd0, r1_gnt}, {31'd0, eg1});
    check({name, "_m_ce"}, {31'd0, m_ce}, {31'd0, eg0 | eg1});
    $display("txn %s: r0_req=%0b r1_req=%0b gnt0=%0b gnt1=%0b m_addr=0x%03h m_we=%h",
             name, q0, q1, r0_gnt, r1_gnt, m_addr, m_we);
    if (push) begin
      e.port = eg1;
      e.data = erd;
      sb_q.push_back(e);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pl_a [4];
    logic [31:0] pl_d [4];
    pl_a = '{32'h010, 32'h020, 32'h001, 32'h002};
    pl_d = '{32'hDEADBEEF, 32'hFFFFFFFF, 32'hA5A50001, 32'h5A5A0002};

    // reset with both ports requesting: nothing may leak out
    rstn = 1'b0; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    r0_req = 1'b1; r0_we = 4'hF; r0_addr = 10'h3FF; r0_wdata = 32'hFFFFFFFF;
    r1_req = 1'b1; r1_we = 4'h0; r1_addr = 10'h155; r1_wdata = 32'h55555555;
    #2;
    check("rst_gnt0", {31'd0, r0_gnt}, 32'h0);
    check("rst_gnt1", {31'd0, r1_gnt}, 32'h0);
    check("rst_m_ce", {31'd0, m_ce}, 32'h0);
    check("rst_m_we", {28'd0, m_we}, 32'h0);
    check("rst_m_addr", {22'd0, m_addr}, 32'h0);
    check("rst_m_data_in", m_data_in, 32'h0);
    check("rst_rvalid", {30'd0, r1_rvalid, r0_rvalid}, 32'h0);

    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      pl_en = 1'b1; pl_addr = pl_a[i][9:0]; pl_data = pl_d[i];
    end
    @(negedge clk);
    pl_en = 1'b0;

    // r0 read in the first cycle after reset release
    rstn = 1'b1;
    drive("s30_r0_rd", 1, 4'h0, 10'h010, 0, 0, 4'h0, 10'h0, 0, 1, 0, 1, 32'hDEADBEEF);
    check("s30_m_addr", {22'd0, m_addr}, 32'h010);
    check("s30_m_we", {28'd0, m_we}, 32'h0);
    @(negedge clk);

    // write to a register-mapped address passes through unchanged
    drive("s34_r0_wr", 1, 4'hF, 10'h204, 32'h1, 0, 4'h0, 10'h0, 0, 1, 0, 0, 0);
    check("s34_m_addr", {22'd0, m_addr}, 32'h204);
    check("s34_m_we", {28'd0, m_we}, 32'hF);
    check("s34_m_data_in", m_data_in, 32'h1);
    @(negedge clk);

    // partial write by r1, then r0 reads the merged word
    drive("s32_r1_wr", 0, 4'h0, 10'h0, 0, 1, 4'b0011, 10'h020, 32'h12345678, 0, 1, 0, 0);
    check("s32_m_we", {28'd0, m_we}, 32'h3);
    check("s32_m_data_in", m_data_in, 32'h12345678);
    @(negedge clk);
    drive("s32_r0_rd", 1, 4'h0, 10'h020, 0, 0, 4'h0, 10'h0, 0, 1, 0, 1, 32'hFFFF5678);
    @(negedge clk);

    // alternating back-to-back reads
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0)
        drive("s35_r0_rd", 1, 4'h0, 10'h001, 0, 0, 4'h0, 10'h0, 0, 1, 0, 1, 32'hA5A50001);
      else
        drive("s35_r1_rd", 0, 4'h0, 10'h0, 0, 1, 4'h0, 10'h002, 0, 0, 1, 1, 32'h5A5A0002);
      @(negedge clk);
    end

    // idle with junk on the inputs: memory side must be all zero
    drive("idle", 0, 4'hF, 10'h3FF, 32'hFFFFFFFF, 0, 4'hF, 10'h2AA, 32'hAAAAAAAA, 0, 0, 0, 0);
    check("idle_m_we", {28'd0, m_we}, 32'h0);
    check("idle_m_addr", {22'd0, m_addr}, 32'h0);
    check("idle_m_data_in", m_data_in, 32'h0);
    @(negedge clk);

    // r0 grant leaves prio on r1; then r1 read is killed by a reset pulse
    drive("s33_r0_wr", 1, 4'hF, 10'h100, 32'h0, 0, 4'h0, 10'h0, 0, 1, 0, 0, 0);
    @(negedge clk);
    drive("s33_r1_rd", 0, 4'h0, 10'h0, 0, 1, 4'h0, 10'h001, 0, 0, 1, 0, 0);
    #1;
    rstn = 1'b0;
    r0_req = 1'b1;
    #1;
    check("s33_rst_gnt0", {31'd0, r0_gnt}, 32'h0);
    check("s33_rst_gnt1", {31'd0, r1_gnt}, 32'h0);
    check("s33_rst_m_ce", {31'd0, m_ce}, 32'h0);
    r0_req = 1'b0; r1_req = 1'b0;
    #1;
    rstn = 1'b1;
    @(negedge clk);

    // both request continuously: r0 first (prio cleared by reset), then alternate
    for (int i = 0; i < 6; i++) begin
      drive("s31_both_rd", 1, 4'h0, 10'h010, 0, 1, 4'h0, 10'h002, 0,
            (i % 2 == 0), (i % 2 == 1), 1,
            (i % 2 == 0) ? 32'hDEADBEEF : 32'h5A5A0002);
      @(negedge clk);
    end

    r0_req = 1'b0; r1_req = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("sb_drained", sb_q.size(), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_dmem_port_arbiter
